// File: rtl/coprocessor.sv
// ---------------------------------------------------------------------------
// coprocessor -- 5x5 signed 8-bit matrix coprocessor
//
// Element (r,c) of every matrix port sits at bits [8*(5r+c) +: 8], two's
// complement. Ops 000..101 and 111 are single-cycle. Each result is computed
// at full precision, wrapped to 8 bits, and flagged in overflow.
// Op 110 (determinant) is built only when COPROCESSOR_DET_EN is defined. It
// runs a Bareiss elimination on 64-bit work registers and reports the
// determinant in result_final[63:0]. Without the macro, op 110 returns zero.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        level request that launches a determinant (op 110)
//   op_code      000 A+B, 001 A-B, 010 A*B, 011 scalar*A, 100 A^T,
//                101 -A, 110 det(A), 111 reserved (zero)
//   matrix_a     operand A (5x5 x int8)
//   matrix_b     operand B (5x5 x int8)
//   scalar       signed 8-bit multiplier for op 011
//   result_final registered 5x5 x int8 result (det: [63:0] signed)
//   overflow     registered; some full-precision element is outside int8
// ---------------------------------------------------------------------------
module coprocessor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op_code,
  input  logic [199:0] matrix_a,
  input  logic [199:0] matrix_b,
  input  logic [7:0]   scalar,
  output logic [199:0] result_final,
  output logic         overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_SCL = 3'b011;
  localparam logic [2:0] OP_TRN = 3'b100;
  localparam logic [2:0] OP_NEG = 3'b101;

  // Sign-extend element (r,c) to 19 bits. Five 16-bit products fit in 19 bits.
  function automatic logic signed [18:0] elem(input logic [199:0] m,
                                              input int r, input int c);
    logic [7:0] e;
    e = m[8*(5*r+c) +: 8];
    return {{11{e[7]}}, e};
  endfunction

  logic signed [18:0] w_scalar;
  logic [199:0]       w_alu_res;
  logic               w_alu_ovf;

  assign w_scalar = {{11{scalar[7]}}, scalar};

  // NOTE: every output of this block is assigned a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    logic signed [18:0] v;
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        v = '0;
        case (op_code)
          OP_ADD: v = elem(matrix_a, r, c) + elem(matrix_b, r, c);
          OP_SUB: v = elem(matrix_a, r, c) - elem(matrix_b, r, c);
          OP_MUL: for (int k = 0; k < 5; k++)
                    v = v + elem(matrix_a, r, k) * elem(matrix_b, k, c);
          OP_SCL: v = elem(matrix_a, r, c) * w_scalar;
          OP_TRN: v = elem(matrix_a, c, r);
          OP_NEG: v = -elem(matrix_a, r, c);
          default: v = '0;  // 111 (and 110 when no det logic is built)
        endcase
        w_alu_res[8*(5*r+c) +: 8] = v[7:0];
        if (v > 19'sd127 || v < -19'sd128) w_alu_ovf = 1'b1;
      end
    end
  end

`ifdef COPROCESSOR_DET_EN
  localparam logic [2:0] OP_DET = 3'b110;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ELIM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic signed [127:0] wide(input logic signed [63:0] x);
    return {{64{x[63]}}, x};
  endfunction

  logic [1:0]         r_state;
  logic signed [63:0] r_a [5][5];
  logic signed [63:0] r_prev;      // previous pivot (Bareiss divisor)
  logic               r_neg;       // odd number of row swaps so far
  logic [2:0]         r_k, r_i, r_j;

  logic               w_is_det;
  logic signed [63:0] w_piv, w_div, w_new, w_det_val;
  logic               w_swap_found, w_det_wr, w_det_ovf;
  logic [2:0]         w_swap_row;

  assign w_is_det = (op_code == OP_DET);
  assign w_piv    = r_a[r_k][r_k];
  // r_prev is only zero outside ELIM (after reset). Use 1 there so the
  // unused quotient stays defined.
  assign w_div    = (r_prev == '0) ? 64'sd1 : r_prev;
  // The 128-bit numerator keeps the exact product. After the exact division
  // the quotient is a minor of A and fits in 64 bits.
  assign w_new    = 64'((wide(w_piv) * wide(r_a[r_i][r_j])
                        - wide(r_a[r_i][r_k]) * wide(r_a[r_k][r_j])) / wide(w_div));

  // Find the first row below the pivot with a nonzero entry in column k.
  // The loop scans downward, so the lowest matching index is written last.
  always_comb begin
    w_swap_found = 1'b0;
    w_swap_row   = r_k;
    for (int r = 4; r >= 1; r--) begin
      if (3'(r) > r_k && r_a[r][r_k] != '0) begin
        w_swap_found = 1'b1;
        w_swap_row   = 3'(r);
      end
    end
  end

  // The determinant is final on the last update of pivot 3. It is also
  // final on a singular column, where the value is zero.
  assign w_det_wr  = (r_state == S_ELIM) &&
                     ((w_piv == '0 && !w_swap_found) || (w_piv != '0 && r_k == 3'd3));
  assign w_det_val = (w_piv == '0) ? '0 : (r_neg ? -w_new : w_new);
  assign w_det_ovf = (w_det_val > 64'sd127) || (w_det_val < -64'sd128);

  // NOTE: all state uses non-blocking assignments. Every register then reads
  // its pre-edge value, including both halves of the row swap below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_prev  <= '0;
      r_neg   <= 1'b0;
      r_k     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      // NOTE: the work array is reset explicitly, so an aborted run leaves
      // no trace. It is a small register file, not RAM, so this stays cheap.
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          r_a[r][c] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_is_det && start) r_state <= S_LOAD;
        S_LOAD: begin
          if (!w_is_det) r_state <= S_IDLE;
          else begin
            for (int r = 0; r < 5; r++)
              for (int c = 0; c < 5; c++)
                r_a[r][c] <= {{56{matrix_a[8*(5*r+c)+7]}}, matrix_a[8*(5*r+c) +: 8]};
            r_prev  <= 64'sd1;
            r_neg   <= 1'b0;
            r_k     <= 3'd0;
            r_i     <= 3'd1;
            r_j     <= 3'd1;
            r_state <= S_ELIM;
          end
        end
        S_ELIM: begin
          if (!w_is_det) r_state <= S_IDLE;
          else if (w_piv == '0) begin
            if (w_swap_found) begin
              for (int c = 0; c < 5; c++) begin
                r_a[r_k][c]        <= r_a[w_swap_row][c];
                r_a[w_swap_row][c] <= r_a[r_k][c];
              end
              r_neg <= ~r_neg;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            // Only columns j > k change, so the in-place update never
            // overwrites a value that a later update still reads.
            r_a[r_i][r_j] <= w_new;
            if (r_j != 3'd4) r_j <= r_j + 3'd1;
            else if (r_i != 3'd4) begin
              r_i <= r_i + 3'd1;
              r_j <= r_k + 3'd1;
            end else if (r_k == 3'd3) begin
              r_state <= S_DONE;
            end else begin
              r_prev <= w_piv;
              r_k    <= r_k + 3'd1;
              r_i    <= r_k + 3'd2;
              r_j    <= r_k + 3'd2;
            end
          end
        end
        S_DONE:  if (!start || !w_is_det) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  logic w_unused_start;
  assign w_unused_start = start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_final <= '0;
      overflow     <= 1'b0;
    end
`ifdef COPROCESSOR_DET_EN
    else if (!w_is_det) begin
      result_final <= w_alu_res;
      overflow     <= w_alu_ovf;
    end else if (w_det_wr) begin
      result_final <= {136'd0, w_det_val};
      overflow     <= w_det_ovf;
    end
`else
    else begin
      result_final <= w_alu_res;
      overflow     <= w_alu_ovf;
    end
`endif
  end

endmodule

// File: tb/tb_coprocessor.sv
// ---------------------------------------------------------------------------
// tb_coprocessor -- self-checking bench for coprocessor.
// Table of single-cycle vectors with hand-derived spot values, plus random
// vectors against a small integer model; expectations flow through a
// scoreboard queue. Determinant sequences run when COPROCESSOR_DET_EN is set.
// ---------------------------------------------------------------------------
module tb_coprocessor;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   op_code;
  logic [199:0] matrix_a, matrix_b;
  logic [7:0]   scalar;
  logic [199:0] result_final;
  logic         overflow;

  always #5 clk = ~clk;

  coprocessor dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .scalar(scalar),
    .result_final(result_final), .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] mk_fill(input logic [7:0] v);
    logic [199:0] m;
    for (int i = 0; i < 25; i++) m[8*i +: 8] = v;
    return m;
  endfunction

  function automatic logic [199:0] mk_seq();
    logic [199:0] m;
    for (int i = 0; i < 25; i++) m[8*i +: 8] = 8'(i + 1);
    return m;
  endfunction

  function automatic logic [199:0] set_el(input logic [199:0] m, input int idx, input logic [7:0] v);
    m[8*idx +: 8] = v;
    return m;
  endfunction

  function automatic int el(input logic [199:0] m, input int idx);
    logic signed [7:0] e;
    e = m[8*idx +: 8];
    return int'(e);
  endfunction

  // Integer reference model for the single-cycle ops.
  task automatic model(input logic [2:0] op, input logic [199:0] a, input logic [199:0] b,
                       input logic [7:0] s, output logic [199:0] res, output logic ovf);
    int v;
    res = '0;
    ovf = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        case (op)
          3'd0: v = el(a, 5*r+c) + el(b, 5*r+c);
          3'd1: v = el(a, 5*r+c) - el(b, 5*r+c);
          3'd2: begin
            v = 0;
            for (int k = 0; k < 5; k++) v += el(a, 5*r+k) * el(b, 5*k+c);
          end
          3'd3: v = int'($signed(s)) * el(a, 5*r+c);
          3'd4: v = el(a, 5*c+r);
          3'd5: v = -el(a, 5*r+c);
          default: v = 0;
        endcase
        res[8*(5*r+c) +: 8] = v[7:0];
        if (v > 127 || v < -128) ovf = 1'b1;
      end
    end
  endtask

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [199:0] a;
    logic [199:0] b;
    logic [7:0]   s;
    int           idx;
    logic [7:0]   exp_el;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    string        name;
    logic [199:0] res;
    logic         ovf;
    int           idx;
    logic [7:0]   el;
    logic         el_ovf;
    bit           spot;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic drive(input string name, input logic [2:0] op, input logic [199:0] a,
                       input logic [199:0] b, input logic [7:0] s, input bit spot,
                       input int idx, input logic [7:0] e_el, input logic e_ovf);
    exp_t e;
    op_code = op; matrix_a = a; matrix_b = b; scalar = s;
    model(op, a, b, s, e.res, e.ovf);
    e.name = name; e.idx = idx; e.el = e_el; e.el_ovf = e_ovf; e.spot = spot;
    sb.push_back(e);
  endtask

  task automatic compare_one();
    exp_t e;
    e = sb.pop_front();
    check({e.name, ".res"}, result_final, e.res);
    if (e.spot) begin
      check({e.name, ".elem"}, {192'd0, result_final[8*e.idx +: 8]}, {192'd0, e.el});
      check({e.name, ".ovf"}, {199'd0, overflow}, {199'd0, e.el_ovf});
    end else begin
      check({e.name, ".ovf"}, {199'd0, overflow}, {199'd0, e.ovf});
    end
  endtask

`ifdef COPROCESSOR_DET_EN
  function automatic logic [199:0] mk_diag(input logic [7:0] v);
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < 5; i++) m[8*(6*i) +: 8] = v;
    return m;
  endfunction

  // Leave a known nonzero result (all 2s) so a missing det write is visible.
  task automatic prime();
    start = 1'b0; op_code = 3'd0; matrix_a = mk_fill(8'd1); matrix_b = mk_fill(8'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_det(input string name, input logic [199:0] a, input longint det,
                         input logic exp_ovf);
    logic [63:0] d;
    d = 64'(det);
    prime();
    op_code = 3'b110; matrix_a = a; start = 1'b1;
    @(posedge clk); #1;
    check({name, ".hold_busy"}, result_final, mk_fill(8'd2));
    repeat (63) @(posedge clk);
    #1;
    check({name, ".det"}, result_final, {136'd0, d});
    check({name, ".ovf"}, {199'd0, overflow}, {199'd0, exp_ovf});
    repeat (3) @(posedge clk);
    #1;
    check({name, ".hold_done"}, result_final, {136'd0, d});
    start = 1'b0;
    @(posedge clk); #1;
    check({name, ".hold_idle"}, result_final, {136'd0, d});
  endtask
`endif

  initial begin
    logic [199:0] a_seq, b_one, z, f127, f80;
    rst = 1'b0; start = 1'b0; op_code = 3'b111;
    matrix_a = '0; matrix_b = '0; scalar = '0;
    a_seq = mk_seq(); b_one = mk_fill(8'd1); z = '0;
    f127 = mk_fill(8'h7F); f80 = mk_fill(8'h80);

    vecs.push_back('{"add",      3'd0, a_seq,                    b_one, 8'd0,  24, 8'd26,  1'b0});
    vecs.push_back('{"sub",      3'd1, a_seq,                    b_one, 8'd0,  24, 8'd24,  1'b0});
    vecs.push_back('{"mul_r4",   3'd2, a_seq,                    b_one, 8'd0,  24, 8'd115, 1'b0});
    vecs.push_back('{"mul_r1",   3'd2, a_seq,                    b_one, 8'd0,   5, 8'd40,  1'b0});
    vecs.push_back('{"scl3",     3'd3, a_seq,                    b_one, 8'd3,  24, 8'd75,  1'b0});
    vecs.push_back('{"scl6",     3'd3, a_seq,                    b_one, 8'd6,  24, 8'h96,  1'b1});
    vecs.push_back('{"trn",      3'd4, a_seq,                    b_one, 8'd0,   1, 8'd6,   1'b0});
    vecs.push_back('{"neg_m128", 3'd5, set_el(a_seq, 0, 8'h80),  b_one, 8'd0,   0, 8'h80,  1'b1});
    vecs.push_back('{"rsv",      3'd7, a_seq,                    b_one, 8'd0,  24, 8'd0,   1'b0});
    vecs.push_back('{"mul_max",  3'd2, f127,                     f127,  8'd0,   0, 8'd5,   1'b1});
    vecs.push_back('{"add_max",  3'd0, f127,                     f127,  8'd0,   0, 8'hFE,  1'b1});
    vecs.push_back('{"sub_min",  3'd1, f80,                      f127,  8'd0,   0, 8'h01,  1'b1});
    vecs.push_back('{"neg_127",  3'd5, f127,                     z,     8'd0,   0, 8'h81,  1'b0});
    vecs.push_back('{"add_edge", 3'd0, f127,                     z,     8'd0,   0, 8'h7F,  1'b0});
    vecs.push_back('{"scl_m128", 3'd3, b_one,                    z,     8'h80,  0, 8'h80,  1'b0});
    vecs.push_back('{"trn_min",  3'd4, f80,                      z,     8'd0,   0, 8'h80,  1'b0});
    vecs.push_back('{"sub_wrap", 3'd1, z,                        f80,   8'd0,   0, 8'h80,  1'b1});

    // Asynchronous reset, visible before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("reset.res", result_final, '0);
    check("reset.ovf", {199'd0, overflow}, '0);
    @(posedge clk); #1;
    check("reset_clk.res", result_final, '0);
    rst = 1'b0;

    // The first vector is driven straight out of reset, with no idle cycles.
    foreach (vecs[i]) begin
      drive(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s, 1'b1,
            vecs[i].idx, vecs[i].exp_el, vecs[i].exp_ovf);
      @(posedge clk); #1;
      compare_one();
    end

    for (int n = 0; n < 6; n++) begin
      logic [199:0] ra, rb;
      for (int i = 0; i < 25; i++) begin
        ra[8*i +: 8] = 8'($urandom_range(0, 255));
        rb[8*i +: 8] = 8'($urandom_range(0, 255));
      end
      drive($sformatf("rand%0d", n), 3'($urandom_range(0, 5)), ra, rb,
            8'($urandom_range(0, 255)), 1'b0, 0, 8'd0, 1'b0);
      @(posedge clk); #1;
      compare_one();
    end

`ifdef COPROCESSOR_DET_EN
    begin
      logic [199:0] swp, low;
      swp = '0;
      swp = set_el(swp, 1, 8'd1);  swp = set_el(swp, 5, 8'd1);
      swp = set_el(swp, 12, 8'd1); swp = set_el(swp, 18, 8'd1); swp = set_el(swp, 24, 8'd1);
      low = '0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < r; c++) low = set_el(low, 5*r+c, 8'd5);
      low = set_el(low, 0, 8'd2);  low = set_el(low, 6, 8'hFF); low = set_el(low, 12, 8'd3);
      low = set_el(low, 18, 8'd1); low = set_el(low, 24, 8'hFE);

      run_det("det_seq",  a_seq,            0,   1'b0);
      run_det("det_2i",   mk_diag(8'd2),    32,  1'b0);
      run_det("det_swap", swp,              -1,  1'b0);
      run_det("det_3i",   mk_diag(8'd3),    243, 1'b1);
      run_det("det_low",  low,              12,  1'b0);

      // Abort: leaving op 110 mid-elimination returns to IDLE and the
      // non-det result is taken; returning with start high begins afresh.
      prime();
      op_code = 3'b110; matrix_a = mk_diag(8'd2); start = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      op_code = 3'd0; matrix_a = a_seq; matrix_b = b_one;
      @(posedge clk); #1;
      check("abort.res", result_final[199:192], 8'd26);
      op_code = 3'b110; matrix_a = mk_diag(8'd2);
      @(posedge clk); #1;
      check("abort.hold", result_final[199:192], 8'd26);
      repeat (63) @(posedge clk);
      #1;
      check("abort.redet", result_final, {136'd0, 64'd32});

      // Reset on ELIM cycle 10: edge 1 enters LOAD, edge 2 enters ELIM.
      start = 1'b0;
      @(posedge clk); #1;
      prime();
      op_code = 3'b110; matrix_a = mk_diag(8'd2); start = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid.res", result_final, '0);
      check("rst_mid.ovf", {199'd0, overflow}, '0);
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_mid.idle_hold", result_final, '0);
      start = 1'b1;
      repeat (64) @(posedge clk);
      #1;
      check("rst_mid.redet", result_final, {136'd0, 64'd32});
      check("rst_mid.redet_ovf", {199'd0, overflow}, '0);
      start = 1'b0;
    end
`else
    // Without det logic, op 110 behaves as reserved: zero result, start ignored.
    op_code = 3'd0; matrix_a = b_one; matrix_b = b_one;
    @(posedge clk); #1;
    op_code = 3'b110; matrix_a = mk_fill(8'd2); start = 1'b1;
    @(posedge clk); #1;
    check("nodet.res", result_final, '0);
    check("nodet.ovf", {199'd0, overflow}, '0);
    repeat (3) @(posedge clk);
    #1;
    check("nodet.stay", result_final, '0);
    start = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
